// File: rtl/hazard_ctrl.sv
// Decode/execute hazard controller: load-use stalls, redirect flushes with a
// call/ret drain window, and sticky halt. Optional perf counters under HAZARD_PERF_EN.
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [3:0]       id_rs1,
    input  logic [3:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [3:0]       ex_reg_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_branch,
    input  logic             ex_branch_taken,
    input  logic             ex_call,
    input  logic             ex_ret,
    input  logic             ex_halt,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pc_hazard,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

    state_e     state_q, state_d;
    logic [3:0] drain_left_q, drain_left_d;

    logic luse_s, redir_s, calret_s, stall_evt_s;
    logic pc_stall_s, ifid_stall_s, ifid_flush_s, idex_bubble_s, pc_hazard_s;

    // R0 is hardwired zero, so a load targeting it can never create a dependency.
    function automatic logic load_use(
        input logic       valid,
        input logic [3:0] rs1,
        input logic [3:0] rs2,
        input logic       rs1_used,
        input logic       rs2_used,
        input logic [3:0] rd,
        input logic       reg_write,
        input logic       mem_read
    );
        logic match;
        match = (rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd));
        return valid && mem_read && reg_write && (rd != 4'd0) && match;
    endfunction

    // Hazard conditions decoded from the EX and ID stage fields.
    always_comb begin
        luse_s   = load_use(id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
                            ex_reg_rd, ex_reg_write, ex_mem_read);
        calret_s = ex_call || ex_ret;
        redir_s  = calret_s || (ex_branch && ex_branch_taken);
    end

    // Pipeline controls and next state; halt outranks redirect, redirect outranks load-use.
    always_comb begin
        pc_stall_s    = 1'b0;
        ifid_stall_s  = 1'b0;
        ifid_flush_s  = 1'b0;
        idex_bubble_s = 1'b0;
        pc_hazard_s   = 1'b0;
        stall_evt_s   = 1'b0;
        state_d       = state_q;
        drain_left_d  = drain_left_q;
        case (state_q)
            ST_RUN: begin
                if (ex_halt) begin
                    pc_stall_s    = 1'b1;
                    ifid_stall_s  = 1'b1;
                    idex_bubble_s = 1'b1;
                    state_d       = ST_HALT;
                end else if (redir_s) begin
                    // PC must stay free here so the updater can load the target.
                    ifid_flush_s  = 1'b1;
                    idex_bubble_s = 1'b1;
                    pc_hazard_s   = calret_s;
                    if (calret_s) begin
                        state_d      = ST_DRAIN;
                        drain_left_d = DRAIN_INIT;
                    end else begin
                        state_d      = ST_RUN;
                    end
                end else if (luse_s) begin
                    pc_stall_s    = 1'b1;
                    ifid_stall_s  = 1'b1;
                    idex_bubble_s = 1'b1;
                    stall_evt_s   = 1'b1;
                end else begin
                    state_d       = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Everything in EX/ID is a bubble now, so inputs are not consulted.
                pc_hazard_s   = 1'b1;
                ifid_flush_s  = 1'b1;
                idex_bubble_s = 1'b1;
                if (drain_left_q <= 4'd1) begin
                    state_d      = ST_RUN;
                    drain_left_d = 4'd0;
                end else begin
                    drain_left_d = drain_left_q - 4'd1;
                end
            end
            ST_HALT: begin
                pc_stall_s    = 1'b1;
                ifid_stall_s  = 1'b1;
                idex_bubble_s = 1'b1;
            end
            default: begin
                state_d      = ST_RUN;
                drain_left_d = 4'd0;
            end
        endcase
    end

    // Controller state and drain counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            drain_left_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            drain_left_q <= drain_left_d;
        end
    end

    assign pc_stall    = pc_stall_s;
    assign ifid_stall  = ifid_stall_s;
    assign ifid_flush  = ifid_flush_s;
    assign idex_bubble = idex_bubble_s;
    assign pc_hazard   = pc_hazard_s;
    assign halted      = (state_q == ST_HALT);

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating perf counters, frozen while halted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q == ST_HALT) begin
            stall_cnt_d = stall_cnt_q;
            flush_cnt_d = flush_cnt_q;
        end else begin
            if (stall_evt_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
            if (ifid_flush_s && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end
    end

    // Perf counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    logic unused_perf_s;
    assign unused_perf_s = stall_evt_s;
    assign stall_cnt     = {CNT_W{1'b0}};
    assign flush_cnt     = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed multi-cycle
// sequences and randomized traffic against a cycle-level reference model.
module tb_hazard_ctrl;
    localparam int DRAIN = 2;
    localparam int CW    = 16;

    logic clk, rst_n;
    logic id_valid, id_rs1_used, id_rs2_used;
    logic [3:0] id_rs1, id_rs2, ex_reg_rd;
    logic ex_reg_write, ex_mem_read, ex_branch, ex_branch_taken;
    logic ex_call, ex_ret, ex_halt;
    logic pc_stall, ifid_stall, ifid_flush, idex_bubble, pc_hazard, halted;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_reg_rd(ex_reg_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_branch(ex_branch), .ex_branch_taken(ex_branch_taken),
        .ex_call(ex_call), .ex_ret(ex_ret), .ex_halt(ex_halt),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .pc_hazard(pc_hazard), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Output vector order: {pc_stall, ifid_stall, ifid_flush, idex_bubble, pc_hazard, halted}
    localparam logic [5:0] O_IDLE  = 6'b000000;
    localparam logic [5:0] O_STALL = 6'b110100;
    localparam logic [5:0] O_BR    = 6'b001100;
    localparam logic [5:0] O_CR    = 6'b001110;
    localparam logic [5:0] O_HALT  = 6'b110101;

    function automatic logic [5:0] outs();
        return {pc_stall, ifid_stall, ifid_flush, idex_bubble, pc_hazard, halted};
    endfunction

    task automatic chk6(input string nm, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic chkc(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] exp_cnt(input int v);
`ifdef HAZARD_PERF_EN
        return CW'(v);
`else
        return (v < 0) ? CW'(1) : CW'(0);
`endif
    endfunction

    task automatic idle_in();
        id_valid = 1'b0; id_rs1 = 4'd0; id_rs2 = 4'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_reg_rd = 4'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_branch = 1'b0;
        ex_branch_taken = 1'b0; ex_call = 1'b0; ex_ret = 1'b0; ex_halt = 1'b0;
    endtask

    // ---------------- reference model ----------------
    bit m_halted;
    int m_flush_left;
    int m_stall, m_flush;
    localparam int CMAX = (1 << CW) - 1;

    function automatic bit m_luse();
        bit dep;
        dep = (id_rs1_used && id_rs1 == ex_reg_rd) || (id_rs2_used && id_rs2 == ex_reg_rd);
        return id_valid && ex_mem_read && ex_reg_write && (ex_reg_rd != 4'd0) && dep;
    endfunction

    function automatic bit m_redir();
        return ex_call || ex_ret || (ex_branch && ex_branch_taken);
    endfunction

    function automatic logic [5:0] model_out();
        if (m_halted) return O_HALT;
        if (m_flush_left > 0) return O_CR;
        if (ex_halt) return O_STALL;
        if (m_redir()) return (ex_call || ex_ret) ? O_CR : O_BR;
        if (m_luse()) return O_STALL;
        return O_IDLE;
    endfunction

    task automatic model_reset();
        m_halted = 1'b0; m_flush_left = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_step();
        if (m_halted) begin
        end else if (m_flush_left > 0) begin
            m_flush_left--;
            if (m_flush < CMAX) m_flush++;
        end else if (ex_halt) begin
            m_halted = 1'b1;
        end else if (m_redir()) begin
            if (m_flush < CMAX) m_flush++;
            if (ex_call || ex_ret) m_flush_left = DRAIN;
        end else if (m_luse()) begin
            if (m_stall < CMAX) m_stall++;
        end
    endtask

    task automatic rand_in();
        id_valid = ($urandom_range(0, 3) != 0);
        id_rs1 = 4'($urandom_range(0, 3)); id_rs2 = 4'($urandom_range(0, 3));
        id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
        ex_reg_rd = 4'($urandom_range(0, 3));
        ex_reg_write = 1'($urandom); ex_mem_read = 1'($urandom);
        ex_branch = 1'($urandom); ex_branch_taken = 1'($urandom);
        ex_call = ($urandom_range(0, 15) == 0); ex_ret = ($urandom_range(0, 15) == 0);
        ex_halt = ($urandom_range(0, 199) == 0);
    endtask

    // Async reset pulse starting at a falling edge; returns at negedge+2 with idle inputs.
    task automatic do_reset();
        @(negedge clk);
        idle_in();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk6("reset_outs", outs(), O_IDLE);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic       v, r1u, r2u, rw, mr, br, bt, call, ret, hlt;
        logic [3:0] r1, r2, rd;
        logic [5:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [3:0] r1, input logic r1u,
                                input logic [3:0] r2, input logic r2u, input logic [3:0] rd,
                                input logic rw, input logic mr, input logic br, input logic bt,
                                input logic call, input logic ret, input logic hlt,
                                input logic [5:0] exp);
        vec_t t;
        t.v = v; t.r1 = r1; t.r1u = r1u; t.r2 = r2; t.r2u = r2u; t.rd = rd;
        t.rw = rw; t.mr = mr; t.br = br; t.bt = bt; t.call = call; t.ret = ret;
        t.hlt = hlt; t.exp = exp;
        return t;
    endfunction

    vec_t vecs[14];

    initial begin
        idle_in();
        rst_n = 1'b0;
        #12;
        chk6("por_outs", outs(), O_IDLE);
        chkc("por_stall_cnt", stall_cnt, exp_cnt(0));
        chkc("por_flush_cnt", flush_cnt, exp_cnt(0));
        @(negedge clk);
        rst_n = 1'b1;

        //            v     r1    u1    r2    u2    rd    rw    mr    br    bt    call  ret   hlt
        vecs[0]  = mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE);
        vecs[1]  = mk(1'b1, 4'd3, 1'b1, 4'd5, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_STALL);
        vecs[2]  = mk(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE);
        vecs[3]  = mk(1'b1, 4'd3, 1'b0, 4'd5, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE);
        vecs[4]  = mk(1'b1, 4'd5, 1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_STALL);
        vecs[5]  = mk(1'b0, 4'd3, 1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE);
        vecs[6]  = mk(1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE);
        vecs[7]  = mk(1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE);
        vecs[8]  = mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_BR);
        vecs[9]  = mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE);
        vecs[10] = mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_CR);
        vecs[11] = mk(1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_CR);
        vecs[12] = mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, O_STALL);
        vecs[13] = mk(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_BR);

        foreach (vecs[i]) begin
            do_reset();
            id_valid = vecs[i].v; id_rs1 = vecs[i].r1; id_rs1_used = vecs[i].r1u;
            id_rs2 = vecs[i].r2; id_rs2_used = vecs[i].r2u; ex_reg_rd = vecs[i].rd;
            ex_reg_write = vecs[i].rw; ex_mem_read = vecs[i].mr; ex_branch = vecs[i].br;
            ex_branch_taken = vecs[i].bt; ex_call = vecs[i].call; ex_ret = vecs[i].ret;
            ex_halt = vecs[i].hlt;
            #1 chk6($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Load-use stalls exactly one cycle, then the load leaves EX.
        do_reset();
        id_valid = 1'b1; id_rs1 = 4'd3; id_rs1_used = 1'b1;
        ex_reg_rd = 4'd3; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        #1 chk6("luse_c0", outs(), O_STALL);
        @(negedge clk);
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_reg_rd = 4'd0;
        #1 chk6("luse_c1", outs(), O_IDLE);
        chkc("luse_stall_cnt", stall_cnt, exp_cnt(1));

        // Taken branch flushes one cycle and stays in RUN.
        do_reset();
        ex_branch = 1'b1; ex_branch_taken = 1'b1;
        #1 chk6("br_c0", outs(), O_BR);
        @(negedge clk);
        idle_in();
        #1 chk6("br_c1", outs(), O_IDLE);
        chkc("br_flush_cnt", flush_cnt, exp_cnt(1));

        // Call drains for 1+DRAIN cycles; halt and load-use during drain are ignored.
        do_reset();
        ex_call = 1'b1;
        #1 chk6("call_c0", outs(), O_CR);
        @(negedge clk);
        idle_in();
        ex_halt = 1'b1; id_valid = 1'b1; id_rs1 = 4'd4; id_rs1_used = 1'b1;
        ex_reg_rd = 4'd4; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        #1 chk6("drain_c1", outs(), O_CR);
        @(negedge clk);
        #1 chk6("drain_c2", outs(), O_CR);
        @(negedge clk);
        idle_in();
        #1 chk6("drain_exit", outs(), O_IDLE);
        chkc("drain_flush_cnt", flush_cnt, exp_cnt(3));
        chkc("drain_stall_cnt", stall_cnt, exp_cnt(0));

        // Reset mid-drain returns to RUN at once.
        do_reset();
        ex_ret = 1'b1;
        @(negedge clk);
        idle_in();
        #1 chk6("ret_drain", outs(), O_CR);
        rst_n = 1'b0;
        #1 chk6("rst_mid_drain", outs(), O_IDLE);
        rst_n = 1'b1;
        @(negedge clk);
        #1 chk6("post_rst_run", outs(), O_IDLE);

        // Sticky halt under random inputs, cleared only by async reset.
        do_reset();
        ex_branch = 1'b1; ex_branch_taken = 1'b1;
        @(negedge clk);
        idle_in();
        ex_halt = 1'b1;
        #1 chk6("halt_c0", outs(), O_STALL);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            rand_in();
            #1 chk6($sformatf("halt_hold%0d", c), outs(), O_HALT);
        end
        chkc("halt_flush_frozen", flush_cnt, exp_cnt(1));
        #1 rst_n = 1'b0;
        #1 chk6("halt_async_rst", outs() & 6'b000001, 6'b000000);
        chkc("halt_rst_flush_cnt", flush_cnt, exp_cnt(0));
        chkc("halt_rst_stall_cnt", stall_cnt, exp_cnt(0));
        rst_n = 1'b1;

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            rand_in();
            if ($urandom_range(0, 149) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1 rst_n = 1'b1;
            end
            #1;
            chk6($sformatf("rand_outs%0d", c), outs(), model_out());
            chkc($sformatf("rand_stall_cnt%0d", c), stall_cnt, exp_cnt(m_stall));
            chkc($sformatf("rand_flush_cnt%0d", c), flush_cnt, exp_cnt(m_flush));
            @(posedge clk);
            model_step();
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
